verify_stream: RTL and testbench



---
 rtl/verify_stream.sv | 158 +++++++++++++++
 tb/tb_verify_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/verify_stream.sv
// Keyed multi-word stream verifier: checks enc/dec consistency per word and a
// running keyed hash against a reference, reporting one verdict per message.
module verify_stream #(
    parameter int            W         = 8,
    parameter logic [W-1:0]  KEY       = 8'h5A,
    parameter int            ROT       = 3,
    parameter logic [W-1:0]  HASH_INIT = '0,
    parameter int            MAX_LEN   = 16,
    parameter int            LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [W-1:0]  ref_hash,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  plain,
    input  logic [W-1:0]  enc_in,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          err_enc,
    output logic          err_dec,
    output logic          err_hash,
    output logic          err_len,
    output logic [LW-1:0] mismatch_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic [W-1:0]  r_ref;
    logic [W-1:0]  r_h;

    logic          w_accept;
    logic          w_len_bad;
    logic          w_last;
    logic [W-1:0]  w_enc;
    logic [W-1:0]  w_dec;
    logic          w_enc_bad;
    logic          w_dec_bad;
    logic [W-1:0]  w_h_next;
    logic          w_hash_bad;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (W - n));
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (W - n));
    endfunction

    assign w_enc      = rotl(plain ^ KEY, ROT);
    assign w_dec      = rotr(enc_in, ROT) ^ KEY;
    assign w_enc_bad  = (w_enc != enc_in);
    assign w_dec_bad  = (w_dec != plain);
    assign w_h_next   = rotl(r_h ^ plain, 1) + KEY;
    assign w_hash_bad = (r_h != r_ref);

    assign w_accept   = (r_state == RUN) && in_valid;
    assign w_len_bad  = (len > LW'(MAX_LEN));
    assign w_last     = (r_cnt == (r_len - LW'(1)));

    assign in_ready   = (r_state == RUN);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_bad || (len == '0)) begin
                        w_next = CHECK;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_next = CHECK;
                end
            end
            CHECK:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_ref        <= '0;
            r_h          <= '0;
            pass         <= 1'b0;
            err_enc      <= 1'b0;
            err_dec      <= 1'b0;
            err_hash     <= 1'b0;
            err_len      <= 1'b0;
            mismatch_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len        <= len;
                        r_ref        <= ref_hash;
                        r_h          <= HASH_INIT;
                        r_cnt        <= '0;
                        pass         <= 1'b0;
                        err_enc      <= 1'b0;
                        err_dec      <= 1'b0;
                        err_hash     <= 1'b0;
                        err_len      <= w_len_bad;
                        mismatch_idx <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_h   <= w_h_next;
                        r_cnt <= r_cnt + LW'(1);
                        if (w_enc_bad) err_enc <= 1'b1;
                        if (w_dec_bad) err_dec <= 1'b1;
                        // Only the first failing word's index is kept.
                        if ((w_enc_bad || w_dec_bad) && !(err_enc || err_dec)) begin
                            mismatch_idx <= r_cnt;
                        end
                    end
                end
                CHECK: begin
                    err_hash <= !err_len && w_hash_bad;
                    pass     <= !(err_enc || err_dec || err_len || (!err_len && w_hash_bad));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_verify_stream.sv
// Directed self-checking bench for verify_stream with hand-computed vectors
// (KEY=5A, ROT=3, HASH_INIT=00).
module tb_verify_stream;

    localparam int W  = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  ref_hash = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  plain = '0;
    logic [W-1:0]  enc_in = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          err_enc;
    logic          err_dec;
    logic          err_hash;
    logic          err_len;
    logic [LW-1:0] mismatch_idx;

    int n_cmp = 0;
    int n_err = 0;

    verify_stream #(
        .W(W), .KEY(8'h5A), .ROT(3), .HASH_INIT(8'h00), .MAX_LEN(16), .LW(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .ref_hash(ref_hash),
        .in_valid(in_valid), .in_ready(in_ready), .plain(plain), .enc_in(enc_in),
        .busy(busy), .done(done), .pass(pass), .err_enc(err_enc), .err_dec(err_dec),
        .err_hash(err_hash), .err_len(err_len), .mismatch_idx(mismatch_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [LW-1:0] l, input logic [W-1:0] rh);
        start    = 1'b1;
        len      = l;
        ref_hash = rh;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] p, input logic [W-1:0] c);
        int n;
        n        = 0;
        plain    = p;
        enc_in   = c;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic verdict(input string tag, input logic p, input logic ee, input logic ed,
                           input logic eh, input logic el, input logic [LW-1:0] idx);
        check({tag, "_pass"},     pass,         p);
        check({tag, "_err_enc"},  err_enc,      ee);
        check({tag, "_err_dec"},  err_dec,      ed);
        check({tag, "_err_hash"}, err_hash,     eh);
        check({tag, "_err_len"},  err_len,      el);
        check({tag, "_idx"},      mismatch_idx, idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        verdict("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // len=1, (00,D2), ref 5A -> pass; check latency around the last word
        start_msg(5'd1, 8'h5A);
        check("t1_busy", busy, 1'b1);
        check("t1_in_ready", in_ready, 1'b1);
        send(8'h00, 8'hD2);
        check("t1_check_ready", in_ready, 1'b0);
        check("t1_check_done", done, 1'b0);
        tick();
        check("t1_done", done, 1'b1);
        verdict("t1", 1, 0, 0, 0, 0, 0);
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_busy_off", busy, 1'b0);
        check("t1_hold_pass", pass, 1'b1);

        // len=2, (00,D2),(01,DA), ref 10 -> pass
        start_msg(5'd2, 8'h10);
        send(8'h00, 8'hD2);
        send(8'h01, 8'hDA);
        wait_done();
        verdict("t2a", 1, 0, 0, 0, 0, 0);
        tick();
        // back-to-back start in the cycle after done; ref 11 -> hash error
        start_msg(5'd2, 8'h11);
        check("t2b_busy", busy, 1'b1);
        check("t2b_cleared", pass, 1'b0);
        send(8'h00, 8'hD2);
        send(8'h01, 8'hDA);
        wait_done();
        verdict("t2b", 0, 0, 0, 1, 0, 0);
        tick();

        // len=3 with a bad second word
        start_msg(5'd3, 8'h00);
        send(8'h00, 8'hD2);
        send(8'hFF, 8'h2C);
        send(8'h01, 8'hDA);
        wait_done();
        check("t3_pass", pass, 1'b0);
        check("t3_err_enc", err_enc, 1'b1);
        check("t3_err_dec", err_dec, 1'b1);
        check("t3_idx", mismatch_idx, 5'd1);
        tick();

        // len=0: CHECK then DONE with no words
        start_msg(5'd0, 8'h00);
        check("t4_ready", in_ready, 1'b0);
        check("t4_done_early", done, 1'b0);
        tick();
        check("t4_done", done, 1'b1);
        verdict("t4", 1, 0, 0, 0, 0, 0);
        tick();

        // len=17: length error, hash check skipped
        in_valid = 1'b1;
        start_msg(5'd17, 8'h00);
        check("t5_ready0", in_ready, 1'b0);
        check("t5_done_early", done, 1'b0);
        tick();
        check("t5_ready1", in_ready, 1'b0);
        check("t5_done", done, 1'b1);
        verdict("t5", 0, 0, 0, 0, 1, 0);
        in_valid = 1'b0;
        tick();

        // len=4 with in_valid gaps and a stray start mid-RUN; ref 54
        start_msg(5'd4, 8'h54);
        send(8'h00, 8'hD2);
        tick();
        start = 1'b1;
        len   = 5'd1;
        tick();
        start = 1'b0;
        check("t6_gap_ready", in_ready, 1'b1);
        check("t6_gap_done", done, 1'b0);
        send(8'h01, 8'hDA);
        tick();
        tick();
        send(8'h02, 8'hC2);
        tick();
        tick();
        send(8'h03, 8'hCA);
        check("t6_after_last_ready", in_ready, 1'b0);
        check("t6_after_last_done", done, 1'b0);
        tick();
        check("t6_done", done, 1'b1);
        verdict("t6", 1, 0, 0, 0, 0, 0);
        tick();

        // reset mid-RUN after two bad words, then a fresh message
        start_msg(5'd3, 8'h00);
        send(8'h00, 8'h00);
        send(8'h00, 8'h00);
        check("t7_pre_err_enc", err_enc, 1'b1);
        check("t7_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_ready", in_ready, 1'b0);
        verdict("t7_rst", 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        tick();
        start_msg(5'd1, 8'h59);
        send(8'hFF, 8'h2D);
        wait_done();
        verdict("t7", 1, 0, 0, 0, 0, 0);
        tick();
        check("t7_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
